// File: rtl/multi_lane_acc_pkg.sv
// rtl/multi_lane_acc_pkg.sv - shared state type and lane arithmetic; define MULTI_LANE_ACC_SAT_EN for saturating sums
package multi_lane_acc_pkg;

    // ACCUM collects beats, FULL presents a finished result downstream
    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } acc_state_t;

`ifdef MULTI_LANE_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Lane sums are computed in a 64-bit container, so ACC_W is limited to this
    localparam int MAX_ACC_W = 63;

    // Adds a and b, both held in the low w bits. Bit 64 of the return value
    // flags that the true sum exceeded 2^w-1; bits [w-1:0] hold the clamped
    // (sat=1) or wrapped (sat=0) sum.
    function automatic logic [64:0] lane_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w,
        input bit          sat
    );
        logic [64:0] s;
        logic [64:0] lim;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        ovf = (s > lim);
        if (ovf) begin
            s = sat ? lim : (s & lim);
        end
        return {ovf, s[63:0]};
    endfunction

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - one accumulator lane: sum register, adder, sticky overflow flag
module acc_lane
    import multi_lane_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_fresh,
    input  logic [DATA_W-1:0] i_data,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W-1:0]   r_sum;
    logic               r_ovf;
    logic [64:0]        w_add;
    logic [63-ACC_W:0]  w_unused_hi;

    assign w_add       = lane_add(64'(r_sum), 64'(i_data), ACC_W, SAT_EN);
    assign w_unused_hi = w_add[63:ACC_W];

    assign o_sum = r_sum;
    assign o_ovf = r_ovf;

    // First beat of a result replaces the sum; later beats add to it and keep overflow sticky
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            if (i_fresh) begin
                r_sum <= ACC_W'(i_data);
                r_ovf <= 1'b0;
            end else begin
                r_sum <= w_add[ACC_W-1:0];
                r_ovf <= r_ovf | w_add[64];
            end
        end
    end

endmodule

// File: rtl/multi_lane_accumulator.sv
// rtl/multi_lane_accumulator.sv - multi-lane beat accumulator with valid/ready result handshake; MULTI_LANE_ACC_SAT_EN selects saturation
module multi_lane_accumulator
    import multi_lane_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_clear,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [LANES*DATA_W-1:0] i_in_data,
    input  logic                    i_flush,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [LANES*ACC_W-1:0]  o_out_data,
    output logic [CNT_W-1:0]        o_out_count,
    output logic [LANES-1:0]        o_out_ovf
);

    acc_state_t       r_state;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_consume;
    logic             w_fresh;
    logic             w_done_beat;
    logic             w_flush_hit;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_count_next;

    // A held result may be replaced in the same cycle it is consumed, so there is no bubble
    assign o_in_ready   = (r_state == ACCUM) | i_out_ready;
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_consume    = (r_state == FULL) & i_out_ready;

    // Consuming a result restarts the beat count before this cycle's beat is added
    assign w_base       = w_consume ? '0 : r_count;
    assign w_fresh      = (w_base == '0);
    assign w_count_next = w_base + CNT_W'(w_accept);
    assign w_done_beat  = w_accept & (w_count_next == CNT_W'(DEPTH));
    assign w_flush_hit  = i_flush & (r_state == ACCUM) & (w_count_next != '0);

    // The lane sums, count and state double as the presented result registers while FULL
    assign o_out_valid  = (r_state == FULL);
    assign o_out_count  = r_count;

    // Handshake FSM and beat counter
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ACCUM;
            r_count <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_count <= w_count_next;
                    if (w_done_beat || w_flush_hit) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        r_count <= w_count_next;
                        r_state <= w_done_beat ? FULL : ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_count <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        acc_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_clear (i_clear),
            .i_load  (w_accept),
            .i_fresh (w_fresh),
            .i_data  (i_in_data[g*DATA_W +: DATA_W]),
            .o_sum   (o_out_data[g*ACC_W +: ACC_W]),
            .o_ovf   (o_out_ovf[g])
        );
    end

endmodule

// File: doc/multi_lane_accumulator.md
# multi_lane_accumulator

Parametrised, multi-lane successor to the 8-bit accumulator used at the systolic-array output edge. Sums DEPTH valid beats per lane into ACC_W-bit results, then presents all lanes at once behind a valid/ready handshake. Supports early flush of a partial result and per-lane overflow reporting. Sits between the PE-array column outputs and the result collector.

## Interface
- DATA_W, 8, unsigned input width per lane
- ACC_W, 16, accumulator/result width per lane (ACC_W >= DATA_W)
- LANES, 4, independent lanes (one per array column)
- DEPTH, 8, beats per complete result (>= 1)
- CNT_W, $clog2(DEPTH+1), derived, width of out_count
- clk  in  1  clock, all logic on rising edge
- clear  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- flush  in  1  emit current partial sums early
- out_valid  out  1  result held on out_data
- out_ready  in  1  downstream consumes result
- out_data  out  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W]
- out_count  out  CNT_W  beats summed into the presented result
- out_ovf  out  LANES  per-lane overflow flag for the presented result

## Operation
- States: ACCUM (out_valid=0), FULL (out_valid=1).
- in_ready = !out_valid | out_ready (combinational).
- Accept = in_valid & in_ready. On accept: count==0 → sum_i <= in_i (fresh load, ovf_i <= 0); else sum_i <= sum_i + in_i; count increments.
- Accept making count reach DEPTH → next state FULL, out_count=DEPTH.
- flush in ACCUM with count>0 → FULL with out_count=count (including a beat accepted the same cycle). flush with count==0 and no accept: ignored. flush in FULL: ignored.
- FULL & out_ready → result consumed; count <= 0; state ACCUM unless a beat is accepted that same cycle, in which case it loads fresh (count=1) and any completion rules above apply.
- Arithmetic unsigned, zero-extended DATA_W→ACC_W. out_ovf_i set (sticky until next fresh load) when any addition for lane i exceeds 2^ACC_W-1.
- clear: sums=0, count=0, ovf=0, state ACCUM; out_valid=0, out_data=0, out_count=0, out_ovf=0. clear overrides all inputs, including mid-accumulation and while FULL (result discarded).

## Timing
- out_data/out_count/out_ovf are registers; valid the cycle after the completing accept or flush.
- Latency: last beat accepted at edge N → out_valid high after edge N.
- Result stable while out_valid & !out_ready.
- Throughput: one beat per cycle sustained when out_ready held high; no bubble at result boundaries.
- DEPTH=1: every accepted beat produces a result.

## Configuration
- MULTI_LANE_ACC_SAT_EN defined: on overflow lane sum clamps to 2^ACC_W-1 and stays there; out_ovf set.
- Undefined: sum wraps modulo 2^ACC_W; out_ovf still set on wrap.

## Structure
- Package multi_lane_acc_pkg: state enum (ACCUM, FULL), lane add/saturate function.
- Sub-module acc_lane: one lane's sum register, adder, overflow flag, saturate/wrap; instantiated LANES times by generate. Top holds FSM, counter, handshake.

## Test plan
Config DATA_W=8, ACC_W=10, LANES=2, DEPTH=4 unless stated.
- Reset: clear high 2 cycles, mid-stream → all outputs 0, in_ready=1; next beat loads fresh.
- Basic: lane0 1,2,3,4, lane1 5,5,5,5, out_ready=1 → one cycle after 4th beat out_data lane0=10, lane1=20, out_count=4, out_ovf=0.
- Backpressure: complete result, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_data stable; out_ready=1 → next beat accepted same cycle, new sum starts fresh.
- Flush: beats 7,9 then flush → lane0=16, out_count=2; flush at count 0 → no out_valid.
- Overflow, ACC_W=9: lane0 255×4 → 511 with out_ovf[0]=1 (SAT_EN) / 508 with out_ovf[0]=1 (no macro); lane1 1×4 → 4, out_ovf[1]=0.
- Back-to-back: 12 continuous beats of value 1, out_ready=1 → three results of 4 on consecutive result boundaries, no lost beats.
